// File: rtl/ysyx_210238_ifu_axi_rd_if.sv
// ---------------------------------------------------------------------------
// ysyx_210238_ifu_axi_rd_if
// AXI4 read-only channel bundle (AR + R) between the instruction-fetch
// bridge and the memory system.
//
// Modports:
//   master - drives AR request fields and r_ready, observes ar_ready and the
//            R beat (the bridge side)
//   slave  - the memory side, mirror image of master
//
// Parameter:
//   ID_W   - width of the AR/R ID fields
// ---------------------------------------------------------------------------
interface ysyx_210238_ifu_axi_rd_if #(
  parameter int ID_W = 4
) ();

  logic            ar_valid;
  logic            ar_ready;
  logic [63:0]     ar_addr;
  logic [ID_W-1:0] ar_id;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic [2:0]      ar_prot;

  logic            r_valid;
  logic            r_ready;
  logic [63:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic [ID_W-1:0] r_id;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
    output r_ready,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
    input  r_ready,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id
  );

endinterface

// File: rtl/ysyx_210238_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// ysyx_210238_ifu_axi_rd
// Single-outstanding AXI4 read bridge sitting upstream of the instruction
// fetch unit. One IFU request becomes one single-beat AR transaction; the
// selected 32-bit word of the 64-bit R beat comes back to the IFU as a
// one-cycle o_ram_ready pulse. A flush marks the in-flight fetch as dropped
// so its response is consumed on the bus but never reported.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   i_ram_valid    - fetch request strobe (ignored while busy)
//   i_ram_addr     - fetch byte address
//   i_ram_size     - AXI size code forwarded on AR
//   i_flush        - discard the current/in-flight fetch
//   o_ram_ready    - one-cycle pulse, o_ram_rdata / o_ram_err valid
//   o_ram_rdata    - fetched instruction word (held between pulses)
//   o_ram_err      - response was SLVERR/DECERR, qualifies o_ram_ready
//   o_busy         - bridge has a transaction outstanding
//   axi            - AXI4 read master (AR + R channels)
// ---------------------------------------------------------------------------
module ysyx_210238_ifu_axi_rd #(
  parameter int AXI_ID_W = 4,
  parameter int AXI_ID   = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_ram_valid,
  input  logic [63:0] i_ram_addr,
  input  logic [2:0]  i_ram_size,
  input  logic        i_flush,
  output logic        o_ram_ready,
  output logic [31:0] o_ram_rdata,
  output logic        o_ram_err,
  output logic        o_busy,

  ysyx_210238_ifu_axi_rd_if.master axi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic        drop;
  logic        ram_ready_q;
  logic        ram_err_q;
  logic [31:0] ram_rdata_q;

  logic        ar_valid;
  logic        r_ready;
  logic        accept_req;
  logic        r_done;
  logic        deliver;

  // r_id is not checked and only the error bit of r_resp matters.
  logic        unused_inputs;
  assign unused_inputs = ^{axi.r_id, axi.r_resp[0]};

  // A request is taken only from IDLE and only when it is not being flushed
  // in the very same cycle.
  assign accept_req = (state == ST_IDLE) && i_ram_valid && !i_flush;

  // The final beat closes the transaction; a beat without r_last is simply
  // consumed while r_ready stays high.
  assign r_done  = (state == ST_R) && axi.r_valid && axi.r_last;

  // A flush arriving together with the final beat also suppresses the pulse.
  assign deliver = r_done && !drop && !i_flush;

  // Next-state and handshake strobes. AR is never withdrawn once raised,
  // even across a flush, so the AXI valid/ready rule holds.
  always_comb begin
    state_next = state;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_req) state_next = ST_AR;
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (axi.ar_ready) state_next = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (r_done) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus the request latch, drop flag and registered
  // response. ready/err default low so they can only ever pulse for a
  // single cycle; rdata keeps its last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= 64'd0;
      size_q      <= 3'd0;
      drop        <= 1'b0;
      ram_ready_q <= 1'b0;
      ram_err_q   <= 1'b0;
      ram_rdata_q <= 32'd0;
    end else begin
      state       <= state_next;
      ram_ready_q <= 1'b0;
      ram_err_q   <= 1'b0;

      if (accept_req) begin
        addr_q <= i_ram_addr;
        size_q <= i_ram_size;
        drop   <= 1'b0;
      end

      if ((state != ST_IDLE) && i_flush) begin
        drop <= 1'b1;
      end

      if (deliver) begin
        ram_ready_q <= 1'b1;
        ram_err_q   <= axi.r_resp[1];
        // Bit 2 of the byte address picks the upper or lower 32-bit lane.
        ram_rdata_q <= addr_q[2] ? axi.r_data[63:32] : axi.r_data[31:0];
      end
    end
  end

  assign axi.ar_valid = ar_valid;
  assign axi.ar_addr  = addr_q;
  assign axi.ar_size  = size_q;
  assign axi.ar_id    = AXI_ID_W'(AXI_ID);
  assign axi.ar_len   = 8'd0;
  assign axi.ar_burst = 2'b01;
  assign axi.ar_prot  = 3'b100;
  assign axi.r_ready  = r_ready;

  assign o_ram_ready  = ram_ready_q;
  assign o_ram_err    = ram_err_q;
  assign o_ram_rdata  = ram_rdata_q;
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_210238_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// tb_ysyx_210238_ifu_axi_rd
// Self-checking bench for the IFU AXI read bridge. The bench plays both the
// IFU and the AXI slave. A fetch-level reference model (one optional
// outstanding fetch with "address sent" and "dropped" attributes) predicts
// every output each cycle; a vector table and hand-written sequences add
// explicit expected values for the documented corner cases, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_ysyx_210238_ifu_axi_rd;

  // One cycle of stimulus as seen by the bridge.
  typedef struct {
    logic        rst;
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic        flush;
    logic        ar_ready;
    logic        r_valid;
    logic        r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
  } stim_t;

  // Stimulus plus explicit outputs expected after the following clock edge.
  typedef struct {
    stim_t       s;
    logic        exp_ar_valid;
    logic        exp_r_ready;
    logic        exp_busy;
    logic        exp_ready;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [63:0] exp_ar_addr;
  } vec_t;

  localparam int NV = 16;

  logic        clk;
  logic        rst;
  logic        i_ram_valid;
  logic [63:0] i_ram_addr;
  logic [2:0]  i_ram_size;
  logic        i_flush;
  logic        o_ram_ready;
  logic [31:0] o_ram_rdata;
  logic        o_ram_err;
  logic        o_busy;

  ysyx_210238_ifu_axi_rd_if #(.ID_W(4)) axi ();

  ysyx_210238_ifu_axi_rd #(
    .AXI_ID_W (4),
    .AXI_ID   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ram_valid (i_ram_valid),
    .i_ram_addr  (i_ram_addr),
    .i_ram_size  (i_ram_size),
    .i_flush     (i_flush),
    .o_ram_ready (o_ram_ready),
    .o_ram_rdata (o_ram_rdata),
    .o_ram_err   (o_ram_err),
    .o_busy      (o_busy),
    .axi         (axi)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_mis  = 0;
  int pulses = 0;
  int p0;

  // Fetch-level reference model.
  logic        m_out;      // a fetch is outstanding
  logic        m_ar_done;  // its address has been accepted by the slave
  logic        m_drop;     // it has been flushed
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic        m_pulse;
  logic        m_err;
  logic [31:0] m_rdata;

  vec_t  tbl [NV];
  stim_t rs;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk_s(input logic r, input logic v, input logic [63:0] a,
                                 input logic f, input logic arr, input logic rv,
                                 input logic rl, input logic [63:0] d, input logic [1:0] rr);
    stim_t s;
    s.rst = r; s.valid = v; s.addr = a; s.size = 3'b010; s.flush = f;
    s.ar_ready = arr; s.r_valid = rv; s.r_last = rl; s.r_data = d; s.r_resp = rr;
    return s;
  endfunction

  function automatic stim_t idle_s();
    return mk_s(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
  endfunction

  function automatic vec_t mk_v(input stim_t s, input logic av, input logic rr, input logic bz,
                                input logic rd, input logic er, input logic [31:0] dat,
                                input logic [63:0] aa);
    vec_t v;
    v.s = s; v.exp_ar_valid = av; v.exp_r_ready = rr; v.exp_busy = bz;
    v.exp_ready = rd; v.exp_err = er; v.exp_rdata = dat; v.exp_ar_addr = aa;
    return v;
  endfunction

  // Advance the model by one clock edge given that cycle's inputs.
  task automatic model_step(input stim_t s);
    if (s.rst) begin
      m_out = 0; m_ar_done = 0; m_drop = 0; m_addr = '0; m_size = '0;
      m_pulse = 0; m_err = 0; m_rdata = '0;
      return;
    end
    m_pulse = 0;
    m_err   = 0;
    if (!m_out) begin
      if (s.valid && !s.flush) begin
        m_out = 1; m_ar_done = 0; m_drop = 0; m_addr = s.addr; m_size = s.size;
      end
    end else if (!m_ar_done) begin
      if (s.flush) m_drop = 1;
      if (s.ar_ready) m_ar_done = 1;
    end else begin
      if (s.flush) m_drop = 1;
      if (s.r_valid && s.r_last) begin
        m_out = 0;
        if (!m_drop) begin
          m_pulse = 1;
          m_err   = s.r_resp[1];
          m_rdata = m_addr[2] ? s.r_data[63:32] : s.r_data[31:0];
        end
      end
    end
  endtask

  task automatic check_output();
    if (o_ram_ready === 1'b1) pulses++;
    cmp("ar_valid",  64'(axi.ar_valid), 64'(m_out && !m_ar_done));
    cmp("r_ready",   64'(axi.r_ready),  64'(m_out && m_ar_done));
    cmp("busy",      64'(o_busy),       64'(m_out));
    cmp("ram_ready", 64'(o_ram_ready),  64'(m_pulse));
    cmp("ram_err",   64'(o_ram_err),    64'(m_err));
    cmp("ram_rdata", 64'(o_ram_rdata),  64'(m_rdata));
    cmp("ar_addr",   axi.ar_addr,       m_addr);
    cmp("ar_size",   64'(axi.ar_size),  64'(m_size));
    cmp("ar_id",     64'(axi.ar_id),    64'd0);
    cmp("ar_len",    64'(axi.ar_len),   64'd0);
    cmp("ar_burst",  64'(axi.ar_burst), 64'd1);
    cmp("ar_prot",   64'(axi.ar_prot),  64'd4);
  endtask

  // Called on a falling edge: drive one cycle, let the edge happen, check.
  task automatic apply_stimulus(input stim_t s);
    rst          = s.rst;
    i_ram_valid  = s.valid;
    i_ram_addr   = s.addr;
    i_ram_size   = s.size;
    i_flush      = s.flush;
    axi.ar_ready = s.ar_ready;
    axi.r_valid  = s.r_valid;
    axi.r_last   = s.r_last;
    axi.r_data   = s.r_data;
    axi.r_resp   = s.r_resp;
    axi.r_id     = 4'd0;
    model_step(s);
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  task automatic request(input logic [63:0] a);
    apply_stimulus(mk_s(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00));
  endtask

  task automatic ar_accept();
    apply_stimulus(mk_s(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00));
  endtask

  task automatic r_beat(input logic [63:0] d, input logic last, input logic f);
    apply_stimulus(mk_s(1'b0, 1'b0, 64'd0, f, 1'b0, 1'b1, last, d, 2'b00));
  endtask

  initial begin
    clk = 0; rst = 1; i_ram_valid = 0; i_ram_addr = '0; i_ram_size = '0; i_flush = 0;
    axi.ar_ready = 0; axi.r_valid = 0; axi.r_last = 0; axi.r_data = '0;
    axi.r_resp = '0; axi.r_id = '0;

    // Basic fetch, error response, flush+request in IDLE, and requests
    // landing on the completion cycle and on the pulse cycle.
    tbl[0]  = mk_v(mk_s(0,1,64'h8000_0004,0,0,0,0,64'd0,2'b00),                 1,0,1,0,0,32'h0,        64'h8000_0004);
    tbl[1]  = mk_v(mk_s(0,0,64'd0,0,1,0,0,64'd0,2'b00),                        0,1,1,0,0,32'h0,        64'h8000_0004);
    tbl[2]  = mk_v(mk_s(0,0,64'd0,0,0,1,1,64'h0000_0013_0010_0093,2'b00),      0,0,0,1,0,32'h0000_0013,64'h8000_0004);
    tbl[3]  = mk_v(idle_s(),                                                   0,0,0,0,0,32'h0000_0013,64'h8000_0004);
    tbl[4]  = mk_v(mk_s(0,1,64'h8000_0008,0,0,0,0,64'd0,2'b00),                 1,0,1,0,0,32'h0000_0013,64'h8000_0008);
    tbl[5]  = mk_v(mk_s(0,0,64'd0,0,1,0,0,64'd0,2'b00),                        0,1,1,0,0,32'h0000_0013,64'h8000_0008);
    tbl[6]  = mk_v(mk_s(0,0,64'd0,0,0,1,1,64'hdead_beef_cafe_f00d,2'b10),      0,0,0,1,1,32'hcafe_f00d,64'h8000_0008);
    tbl[7]  = mk_v(idle_s(),                                                   0,0,0,0,0,32'hcafe_f00d,64'h8000_0008);
    tbl[8]  = mk_v(mk_s(0,1,64'h8000_0010,1,0,0,0,64'd0,2'b00),                 0,0,0,0,0,32'hcafe_f00d,64'h8000_0008);
    tbl[9]  = mk_v(idle_s(),                                                   0,0,0,0,0,32'hcafe_f00d,64'h8000_0008);
    tbl[10] = mk_v(mk_s(0,1,64'h8000_0020,0,0,0,0,64'd0,2'b00),                 1,0,1,0,0,32'hcafe_f00d,64'h8000_0020);
    tbl[11] = mk_v(mk_s(0,0,64'd0,0,1,0,0,64'd0,2'b00),                        0,1,1,0,0,32'hcafe_f00d,64'h8000_0020);
    tbl[12] = mk_v(mk_s(0,1,64'h8000_0024,0,0,1,1,64'h1111_1111_2222_2222,2'b00),0,0,0,1,0,32'h2222_2222,64'h8000_0020);
    tbl[13] = mk_v(mk_s(0,1,64'h8000_0024,0,0,0,0,64'd0,2'b00),                 1,0,1,0,0,32'h2222_2222,64'h8000_0024);
    tbl[14] = mk_v(mk_s(0,0,64'd0,0,1,0,0,64'd0,2'b00),                        0,1,1,0,0,32'h2222_2222,64'h8000_0024);
    tbl[15] = mk_v(mk_s(0,0,64'd0,0,0,1,1,64'h3333_3333_4444_4444,2'b00),      0,0,0,1,0,32'h3333_3333,64'h8000_0024);

    @(negedge clk);
    $display("[TB] reset");
    apply_stimulus(mk_s(1,0,64'd0,0,0,0,0,64'd0,2'b00));
    apply_stimulus(mk_s(1,0,64'd0,0,0,0,0,64'd0,2'b00));

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      apply_stimulus(tbl[i].s);
      cmp($sformatf("tbl%0d_ar_valid", i), 64'(axi.ar_valid), 64'(tbl[i].exp_ar_valid));
      cmp($sformatf("tbl%0d_r_ready", i),  64'(axi.r_ready),  64'(tbl[i].exp_r_ready));
      cmp($sformatf("tbl%0d_busy", i),     64'(o_busy),       64'(tbl[i].exp_busy));
      cmp($sformatf("tbl%0d_ready", i),    64'(o_ram_ready),  64'(tbl[i].exp_ready));
      cmp($sformatf("tbl%0d_err", i),      64'(o_ram_err),    64'(tbl[i].exp_err));
      cmp($sformatf("tbl%0d_rdata", i),    64'(o_ram_rdata),  64'(tbl[i].exp_rdata));
      cmp($sformatf("tbl%0d_ar_addr", i),  axi.ar_addr,       tbl[i].exp_ar_addr);
    end

    $display("[TB] backpressure");
    p0 = pulses;
    request(64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(idle_s());
      cmp("bp_ar_valid", 64'(axi.ar_valid), 64'd1);
      cmp("bp_ar_addr",  axi.ar_addr,       64'h8000_0000);
    end
    ar_accept();
    for (int i = 0; i < 3; i++) apply_stimulus(idle_s());
    r_beat(64'habcd_0000_0000_0297, 1'b1, 1'b0);
    apply_stimulus(idle_s());
    cmp("bp_pulses", 64'(pulses - p0), 64'd1);
    cmp("bp_rdata",  64'(o_ram_rdata), 64'h297);

    $display("[TB] flush in AR");
    p0 = pulses;
    request(64'h8000_0040);
    apply_stimulus(mk_s(0,0,64'd0,1,0,0,0,64'd0,2'b00));
    apply_stimulus(idle_s());
    ar_accept();
    cmp("far_r_ready", 64'(axi.r_ready), 64'd1);
    r_beat(64'h7777_7777_8888_8888, 1'b1, 1'b0);
    apply_stimulus(idle_s());
    cmp("far_pulses", 64'(pulses - p0), 64'd0);
    request(64'h8000_0100);
    ar_accept();
    r_beat(64'h5555_5555_6666_6666, 1'b1, 1'b0);
    cmp("far_next_ready", 64'(o_ram_ready), 64'd1);
    cmp("far_next_rdata", 64'(o_ram_rdata), 64'h6666_6666);

    $display("[TB] flush in R");
    p0 = pulses;
    request(64'h8000_0200);
    ar_accept();
    r_beat(64'h0bad_0bad_0bad_0bad, 1'b0, 1'b0);
    cmp("fr_busy_nolast", 64'(o_busy), 64'd1);
    r_beat(64'h1234_5678_9abc_def0, 1'b1, 1'b1);
    cmp("fr_busy", 64'(o_busy), 64'd0);
    apply_stimulus(idle_s());
    cmp("fr_pulses", 64'(pulses - p0), 64'd0);

    $display("[TB] reset mid-R");
    p0 = pulses;
    request(64'h8000_0300);
    ar_accept();
    apply_stimulus(mk_s(1,0,64'd0,0,0,1,1,64'h0000_0001_0000_0001,2'b00));
    cmp("rst_r_ready",  64'(axi.r_ready),  64'd0);
    cmp("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
    cmp("rst_busy",     64'(o_busy),       64'd0);
    cmp("rst_ready",    64'(o_ram_ready),  64'd0);
    request(64'h8000_0304);
    ar_accept();
    r_beat(64'h9999_999a_0000_1111, 1'b1, 1'b0);
    cmp("rst_next_rdata", 64'(o_ram_rdata), 64'h9999_999a);
    cmp("rst_pulses",     64'(pulses - p0), 64'd1);

    $display("[TB] random");
    for (int c = 0; c < 3000; c++) begin
      rs          = idle_s();
      rs.rst      = ($urandom_range(0, 199) == 0);
      rs.valid    = ($urandom_range(0, 9) < 4);
      rs.addr     = {$urandom, $urandom};
      rs.size     = 3'($urandom_range(0, 7));
      rs.flush    = ($urandom_range(0, 9) == 0);
      rs.ar_ready = 1'($urandom_range(0, 1));
      // The slave only returns data once it has accepted the address.
      if (m_out && m_ar_done) begin
        rs.r_valid = 1'($urandom_range(0, 1));
        rs.r_last  = ($urandom_range(0, 4) != 0);
      end
      rs.r_data   = {$urandom, $urandom};
      rs.r_resp   = 2'($urandom_range(0, 3));
      apply_stimulus(rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
